// File: rtl/sail_write_drain.sv
// In-order byte-write drain: buffers per-byte writes in a FIFO, commits one per memory handshake,
// and offers a flush handshake that completes once every pending write has been committed.
module sail_write_drain #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  input  logic [7:0]            in_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_paddr,
  output logic [7:0]            mem_data,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [7:0]            data_mem [DEPTH];

  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic [CNT_WIDTH-1:0] count_q;
  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 overflow_q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // All handshake outputs come from registered occupancy, so nothing on in_valid reaches mem_valid.
  assign full       = (count_q == CNT_WIDTH'(DEPTH));
  assign empty      = (count_q == '0);
  assign in_ready   = !full;
  assign mem_valid  = !empty;
  assign push       = in_valid && !full;
  assign pop        = !empty && mem_ready;
  assign mem_paddr  = addr_mem[rptr];
  assign mem_data   = data_mem[rptr];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign flush_done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr] <= in_paddr;
      data_mem[wptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      if (push) wptr <= wptr + PTR_WIDTH'(1);
      if (pop)  rptr <= rptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      if (in_valid && full) overflow_q <= 1'b1;
      state <= state_next;
    end
  end

  // A push accepted while draining keeps the flush open until that entry has committed too.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (flush_req) state_next = ST_DRAIN;
      ST_DRAIN: if (empty && !push) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

endmodule
